// File: rtl/write_xbar_datapath_pkg.sv
// Shared widths, response codes and payload packing helpers for the write crossbar.
// Payload layouts (MSB first): AW {addr, id}, W {data, strb, last, id}, B {resp, id}.
package axi_xbar_pkg;

   // Index width that never collapses to zero bits for a single port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NUM_OUTSTANDING_TRANS_DEF = 2;
   localparam int ADDR_WIDTH_DEF            = 32;
   localparam int DATA_WIDTH_DEF            = 32;
   localparam int IDW                       = idx_w(NUM_OUTSTANDING_TRANS_DEF);
   localparam int STRB_W                    = DATA_WIDTH_DEF / 8;
   localparam int BRESP_W                   = 2;

   localparam logic [BRESP_W-1:0] BRESP_OKAY   = 2'b00;
   localparam logic [BRESP_W-1:0] BRESP_SLVERR = 2'b10;

   function automatic int aw_pl_w(input int addr_w, input int id_w);
      return addr_w + id_w;
   endfunction

   function automatic int w_pl_w(input int data_w, input int id_w);
      return data_w + data_w / 8 + 1 + id_w;
   endfunction

   function automatic int b_pl_w(input int id_w);
      return BRESP_W + id_w;
   endfunction

endpackage

// File: rtl/write_xbar_datapath_skid.sv
// axi_skid_buffer: 2-entry registered FIFO. Head entry drives dout; full/empty
// decode only the registered count, so downstream valid never depends on ready.
// Ports: clk, clr (async, active-low), push/din (write), pop (read head),
//        dout (head payload), full (2 held), empty (0 held).
module axi_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] ent0_q, ent0_d;
   logic [WIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]       cnt_q, cnt_d;

   assign dout  = ent0_q;
   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      if (pop && !empty) begin
         ent0_d = ent1_q;
         cnt_d  = cnt_q - 2'd1;
      end
      // Push lands after any pop, so push+pop at count 1 refills the head.
      if (push && !full) begin
         if (cnt_d == 2'd0) ent0_d = din;
         else               ent1_d = din;
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/write_xbar_datapath.sv
// write_xbar_datapath: write-path payload crossbar driven by write_arbiter grant/sel.
// AW and W beats route master->slave through per-slave skid buffers; B responses
// route slave->master through per-master skid buffers. Also feeds the arbiter.
// Ports: clk, clr (async, active-low); m_aw_*/m_w_*/m_b_* master side;
//        s_aw_*/s_w_*/s_b_* slave side; *_grant_f/*_sel_f from arbiter;
//        AW_valid_f/AW_addr_f/AW_id_f/W_id_f/B_ready_f/B_valid_f to arbiter.
module write_xbar_datapath
   import axi_xbar_pkg::*;
#(
   parameter  int M                     = 2,
   parameter  int S                     = 2,
   parameter  int NUM_OUTSTANDING_TRANS = 2,
   parameter  int ADDR_WIDTH            = 32,
   parameter  int DATA_WIDTH            = 32,
   localparam int IDP = idx_w(NUM_OUTSTANDING_TRANS),
   localparam int STP = DATA_WIDTH / 8,
   localparam int MSW = idx_w(M),
   localparam int SSW = idx_w(S)
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [M-1:0]            m_aw_valid,
   output logic [M-1:0]            m_aw_ready,
   input  logic [M*ADDR_WIDTH-1:0] m_aw_addr,
   input  logic [M*IDP-1:0]        m_aw_id,
   input  logic [M-1:0]            m_w_valid,
   output logic [M-1:0]            m_w_ready,
   input  logic [M*DATA_WIDTH-1:0] m_w_data,
   input  logic [M*STP-1:0]        m_w_strb,
   input  logic [M-1:0]            m_w_last,
   input  logic [M*IDP-1:0]        m_w_id,
   output logic [M-1:0]            m_b_valid,
   input  logic [M-1:0]            m_b_ready,
   output logic [M*BRESP_W-1:0]    m_b_resp,
   output logic [M*IDP-1:0]        m_b_id,
   output logic [S-1:0]            s_aw_valid,
   input  logic [S-1:0]            s_aw_ready,
   output logic [S*ADDR_WIDTH-1:0] s_aw_addr,
   output logic [S*IDP-1:0]        s_aw_id,
   output logic [S-1:0]            s_w_valid,
   input  logic [S-1:0]            s_w_ready,
   output logic [S*DATA_WIDTH-1:0] s_w_data,
   output logic [S*STP-1:0]        s_w_strb,
   output logic [S-1:0]            s_w_last,
   output logic [S*IDP-1:0]        s_w_id,
   input  logic [S-1:0]            s_b_valid,
   output logic [S-1:0]            s_b_ready,
   input  logic [S*BRESP_W-1:0]    s_b_resp,
   input  logic [S*IDP-1:0]        s_b_id,
   input  logic [M-1:0]            AW_grant_f,
   input  logic [M-1:0]            W_grant_f,
   input  logic [M*SSW-1:0]        AW_sel_f,
   input  logic [M*SSW-1:0]        W_sel_f,
   input  logic [S-1:0]            B_grant_f,
   input  logic [S*MSW-1:0]        B_sel_f,
   output logic [M-1:0]            AW_valid_f,
   output logic [M*ADDR_WIDTH-1:0] AW_addr_f,
   output logic [M*IDP-1:0]        AW_id_f,
   output logic [M*IDP-1:0]        W_id_f,
   output logic [M-1:0]            B_ready_f,
   output logic [S-1:0]            B_valid_f
);

   localparam int AW_W = aw_pl_w(ADDR_WIDTH, IDP);
   localparam int W_W  = w_pl_w(DATA_WIDTH, IDP);
   localparam int B_W  = b_pl_w(IDP);

   logic [AW_W-1:0] m_aw_pl [M];
   logic [W_W-1:0]  m_w_pl  [M];
   logic [B_W-1:0]  s_b_pl  [S];
   logic [SSW-1:0]  aw_sel  [M];
   logic [SSW-1:0]  w_sel   [M];
   logic [MSW-1:0]  b_sel   [S];

   logic [AW_W-1:0] aw_din [S], aw_dout [S];
   logic [W_W-1:0]  w_din  [S], w_dout  [S];
   logic [B_W-1:0]  b_din  [M], b_dout  [M];
   logic [S-1:0]    aw_push, aw_full, aw_empty, aw_claim;
   logic [S-1:0]    w_push,  w_full,  w_empty,  w_claim;
   logic [M-1:0]    b_push,  b_full,  b_empty,  b_claim;

   // Readies stay low until the first clock after reset release.
   logic            run_q, run_d;
   logic [S-1:0]    b_pulse_q, b_pulse_d;

   assign AW_valid_f = m_aw_valid;
   assign AW_addr_f  = m_aw_addr;
   assign AW_id_f    = m_aw_id;
   assign W_id_f     = m_w_id;
   assign B_ready_f  = ~b_full;
   assign B_valid_f  = b_pulse_q;

   for (genvar m = 0; m < M; m++) begin : g_mst
      assign m_aw_pl[m] = {m_aw_addr[m*ADDR_WIDTH +: ADDR_WIDTH], m_aw_id[m*IDP +: IDP]};
      assign m_w_pl[m]  = {m_w_data[m*DATA_WIDTH +: DATA_WIDTH], m_w_strb[m*STP +: STP],
                           m_w_last[m], m_w_id[m*IDP +: IDP]};
      assign aw_sel[m]  = AW_sel_f[m*SSW +: SSW];
      assign w_sel[m]   = W_sel_f[m*SSW +: SSW];

      axi_skid_buffer #(.WIDTH(B_W)) u_b_buf (
         .clk(clk), .clr(clr), .push(b_push[m]), .din(b_din[m]),
         .pop(m_b_ready[m]), .dout(b_dout[m]), .full(b_full[m]), .empty(b_empty[m])
      );
      assign m_b_valid[m]                = !b_empty[m];
      assign m_b_resp[m*BRESP_W +: BRESP_W] = b_dout[m][IDP +: BRESP_W];
      assign m_b_id[m*IDP +: IDP]        = b_dout[m][IDP-1:0];
   end

   for (genvar s = 0; s < S; s++) begin : g_slv
      assign s_b_pl[s] = {s_b_resp[s*BRESP_W +: BRESP_W], s_b_id[s*IDP +: IDP]};
      assign b_sel[s]  = B_sel_f[s*MSW +: MSW];

      axi_skid_buffer #(.WIDTH(AW_W)) u_aw_buf (
         .clk(clk), .clr(clr), .push(aw_push[s]), .din(aw_din[s]),
         .pop(s_aw_ready[s]), .dout(aw_dout[s]), .full(aw_full[s]), .empty(aw_empty[s])
      );
      axi_skid_buffer #(.WIDTH(W_W)) u_w_buf (
         .clk(clk), .clr(clr), .push(w_push[s]), .din(w_din[s]),
         .pop(s_w_ready[s]), .dout(w_dout[s]), .full(w_full[s]), .empty(w_empty[s])
      );

      assign s_aw_valid[s]                     = !aw_empty[s];
      assign s_aw_addr[s*ADDR_WIDTH +: ADDR_WIDTH] = aw_dout[s][IDP +: ADDR_WIDTH];
      assign s_aw_id[s*IDP +: IDP]             = aw_dout[s][IDP-1:0];
      assign s_w_valid[s]                      = !w_empty[s];
      assign s_w_data[s*DATA_WIDTH +: DATA_WIDTH] = w_dout[s][IDP+1+STP +: DATA_WIDTH];
      assign s_w_strb[s*STP +: STP]            = w_dout[s][IDP+1 +: STP];
      assign s_w_last[s]                       = w_dout[s][IDP];
      assign s_w_id[s*IDP +: IDP]              = w_dout[s][IDP-1:0];
   end

   // A destination is claimed by the lowest-index granted source, even when its
   // buffer is full, so an illegal dual grant never lets a higher index slip in.
   always_comb begin
      aw_push    = '0;
      aw_claim   = '0;
      m_aw_ready = '0;
      w_push     = '0;
      w_claim    = '0;
      m_w_ready  = '0;
      for (int s = 0; s < S; s++) begin
         aw_din[s] = '0;
         w_din[s]  = '0;
      end
      for (int m = 0; m < M; m++) begin
         if (run_q && AW_grant_f[m] && (int'(aw_sel[m]) < S) && !aw_claim[aw_sel[m]]) begin
            aw_claim[aw_sel[m]] = 1'b1;
            m_aw_ready[m]       = !aw_full[aw_sel[m]];
            if (m_aw_valid[m] && !aw_full[aw_sel[m]]) begin
               aw_push[aw_sel[m]] = 1'b1;
               aw_din[aw_sel[m]]  = m_aw_pl[m];
            end
         end
         if (run_q && W_grant_f[m] && (int'(w_sel[m]) < S) && !w_claim[w_sel[m]]) begin
            w_claim[w_sel[m]] = 1'b1;
            m_w_ready[m]      = !w_full[w_sel[m]];
            if (m_w_valid[m] && !w_full[w_sel[m]]) begin
               w_push[w_sel[m]] = 1'b1;
               w_din[w_sel[m]]  = m_w_pl[m];
            end
         end
      end
   end

   always_comb begin
      b_push    = '0;
      b_claim   = '0;
      s_b_ready = '0;
      for (int m = 0; m < M; m++) b_din[m] = '0;
      for (int s = 0; s < S; s++) begin
         if (run_q && B_grant_f[s] && (int'(b_sel[s]) < M) && !b_claim[b_sel[s]]) begin
            b_claim[b_sel[s]] = 1'b1;
            s_b_ready[s]      = !b_full[b_sel[s]];
            if (s_b_valid[s] && !b_full[b_sel[s]]) begin
               b_push[b_sel[s]] = 1'b1;
               b_din[b_sel[s]]  = s_b_pl[s];
            end
         end
      end
      b_pulse_d = s_b_valid & s_b_ready;
      run_d     = 1'b1;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         run_q     <= 1'b0;
         b_pulse_q <= '0;
      end else begin
         run_q     <= run_d;
         b_pulse_q <= b_pulse_d;
      end
   end

endmodule

// File: tb/tb_write_xbar_datapath.sv
module tb_write_xbar_datapath;

   localparam int M = 2, S = 2, A = 32, D = 32, I = 1, ST = 4;

   logic clk, clr;
   logic [M-1:0]   m_aw_valid, m_aw_ready;
   logic [M*A-1:0] m_aw_addr;
   logic [M*I-1:0] m_aw_id;
   logic [M-1:0]   m_w_valid, m_w_ready;
   logic [M*D-1:0] m_w_data;
   logic [M*ST-1:0] m_w_strb;
   logic [M-1:0]   m_w_last;
   logic [M*I-1:0] m_w_id;
   logic [M-1:0]   m_b_valid, m_b_ready;
   logic [M*2-1:0] m_b_resp;
   logic [M*I-1:0] m_b_id;
   logic [S-1:0]   s_aw_valid, s_aw_ready;
   logic [S*A-1:0] s_aw_addr;
   logic [S*I-1:0] s_aw_id;
   logic [S-1:0]   s_w_valid, s_w_ready;
   logic [S*D-1:0] s_w_data;
   logic [S*ST-1:0] s_w_strb;
   logic [S-1:0]   s_w_last;
   logic [S*I-1:0] s_w_id;
   logic [S-1:0]   s_b_valid, s_b_ready;
   logic [S*2-1:0] s_b_resp;
   logic [S*I-1:0] s_b_id;
   logic [M-1:0]   AW_grant_f, W_grant_f;
   logic [M-1:0]   AW_sel_f, W_sel_f;
   logic [S-1:0]   B_grant_f;
   logic [S-1:0]   B_sel_f;
   logic [M-1:0]   AW_valid_f;
   logic [M*A-1:0] AW_addr_f;
   logic [M*I-1:0] AW_id_f, W_id_f;
   logic [M-1:0]   B_ready_f;
   logic [S-1:0]   B_valid_f;

   write_xbar_datapath dut (
      .clk(clk), .clr(clr),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_w_last(m_w_last), .m_w_id(m_w_id),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp), .m_b_id(m_b_id),
      .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
      .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
      .s_w_last(s_w_last), .s_w_id(s_w_id),
      .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp), .s_b_id(s_b_id),
      .AW_grant_f(AW_grant_f), .W_grant_f(W_grant_f), .AW_sel_f(AW_sel_f), .W_sel_f(W_sel_f),
      .B_grant_f(B_grant_f), .B_sel_f(B_sel_f),
      .AW_valid_f(AW_valid_f), .AW_addr_f(AW_addr_f), .AW_id_f(AW_id_f), .W_id_f(W_id_f),
      .B_ready_f(B_ready_f), .B_valid_f(B_valid_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_w(input int m, input logic [31:0] data, input logic last);
      m_w_valid[m]        = 1'b1;
      m_w_data[m*D +: D]  = data;
      m_w_strb[m*ST +: ST] = 4'hF;
      m_w_last[m]         = last;
      m_w_id[m]           = 1'b0;
   endtask

   typedef struct {
      int          mi;
      logic        sel;
      logic        gnt;
      logic [31:0] addr;
      logic        id;
      logic        exp_rdy;
      logic [1:0]  exp_sv;
   } aw_vec_t;

   aw_vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{0, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 1'b1, 2'b01};
      vecs[1] = '{0, 1'b1, 1'b1, 32'hDEAD_BEE0, 1'b1, 1'b1, 2'b10};
      vecs[2] = '{1, 1'b0, 1'b1, 32'h2222_0004, 1'b1, 1'b1, 2'b01};
      vecs[3] = '{1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 2'b10};
      vecs[4] = '{1, 1'b1, 1'b0, 32'h3333_0000, 1'b0, 1'b0, 2'b00};
      vecs[5] = '{0, 1'b0, 1'b0, 32'h4444_0008, 1'b1, 1'b0, 2'b00};

      clr = 1'b1;
      m_aw_valid = '0; m_aw_addr = '0; m_aw_id = '0;
      m_w_valid = '0; m_w_data = '0; m_w_strb = '0; m_w_last = '0; m_w_id = '0;
      m_b_ready = '0;
      s_aw_ready = '1; s_w_ready = '1;
      s_b_valid = '1; s_b_resp = '0; s_b_id = '0;
      AW_grant_f = '1; W_grant_f = '1; AW_sel_f = '0; W_sel_f = '0;
      B_grant_f = '1; B_sel_f = '0;
      #2 clr = 1'b0;
      #10;
      // Reset: everything quiet even with grants and slave B valid asserted.
      chk("rst s_aw_valid", s_aw_valid, 0);
      chk("rst s_w_valid",  s_w_valid, 0);
      chk("rst m_b_valid",  m_b_valid, 0);
      chk("rst m_aw_ready", m_aw_ready, 0);
      chk("rst m_w_ready",  m_w_ready, 0);
      chk("rst s_b_ready",  s_b_ready, 0);
      chk("rst B_valid_f",  B_valid_f, 0);

      @(negedge clk);
      clr = 1'b1;
      AW_grant_f = '0; W_grant_f = '0; B_grant_f = '0; s_b_valid = '0;
      @(negedge clk);

      // Test 1: single AW beat to slave 1.
      m_aw_valid[0] = 1'b1; m_aw_addr[31:0] = 32'h0001_0040; m_aw_id[0] = 1'b1;
      AW_grant_f[0] = 1'b1; AW_sel_f[0] = 1'b1;
      #1 chk("t1 m_aw_ready", m_aw_ready, 2'b01);
      @(posedge clk); #1;
      chk("t1 s_aw_valid", s_aw_valid, 2'b10);
      chk("t1 s_aw_addr",  s_aw_addr[63:32], 32'h0001_0040);
      chk("t1 s_aw_id",    s_aw_id[1], 1'b1);
      @(negedge clk);
      m_aw_valid = '0; AW_grant_f = '0; AW_sel_f = '0;
      @(posedge clk); #1;
      chk("t1 drained", s_aw_valid, 2'b00);

      // Table: AW routing vectors.
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         m_aw_valid[vecs[v].mi]          = 1'b1;
         m_aw_addr[vecs[v].mi*A +: A]    = vecs[v].addr;
         m_aw_id[vecs[v].mi]             = vecs[v].id;
         AW_grant_f[vecs[v].mi]          = vecs[v].gnt;
         AW_sel_f[vecs[v].mi]            = vecs[v].sel;
         #1;
         chk($sformatf("vec%0d ready", v), m_aw_ready[vecs[v].mi], vecs[v].exp_rdy);
         chk($sformatf("vec%0d AW_addr_f", v), AW_addr_f[vecs[v].mi*A +: A], vecs[v].addr);
         @(posedge clk); #1;
         chk($sformatf("vec%0d s_aw_valid", v), s_aw_valid, vecs[v].exp_sv);
         if (vecs[v].exp_sv != 2'b00) begin
            chk($sformatf("vec%0d s_aw_addr", v), s_aw_addr[vecs[v].sel*A +: A], vecs[v].addr);
            chk($sformatf("vec%0d s_aw_id", v), s_aw_id[vecs[v].sel], vecs[v].id);
         end
         @(negedge clk);
         m_aw_valid = '0; AW_grant_f = '0; AW_sel_f = '0;
         @(posedge clk); #1;
         chk($sformatf("vec%0d drained", v), s_aw_valid, 2'b00);
      end

      // Test 2: W backpressure, 3 beats into a 2-entry buffer.
      @(negedge clk);
      s_w_ready[0] = 1'b0; W_grant_f[0] = 1'b1; W_sel_f[0] = 1'b0;
      drive_w(0, 32'hA0, 1'b0);
      #1 chk("t2 rdy A0", m_w_ready[0], 1'b1);
      @(negedge clk);
      drive_w(0, 32'hA1, 1'b0);
      #1 chk("t2 rdy A1", m_w_ready[0], 1'b1);
      @(negedge clk);
      drive_w(0, 32'hA2, 1'b1);
      #1 chk("t2 rdy full", m_w_ready[0], 1'b0);
      @(negedge clk);
      s_w_ready[0] = 1'b1;
      #1 chk("t2 rdy still full", m_w_ready[0], 1'b0);
      chk("t2 data A0", {s_w_valid[0], s_w_last[0], s_w_data[31:0]}, {2'b10, 32'hA0});
      @(negedge clk);
      #1 chk("t2 rdy after pop", m_w_ready[0], 1'b1);
      chk("t2 data A1", {s_w_valid[0], s_w_last[0], s_w_data[31:0]}, {2'b10, 32'hA1});
      @(negedge clk);
      m_w_valid = '0;
      #1 chk("t2 data A2", {s_w_valid[0], s_w_last[0], s_w_data[31:0]}, {2'b11, 32'hA2});
      @(negedge clk);
      #1 chk("t2 drained", s_w_valid[0], 1'b0);
      W_grant_f = '0;

      // Test 3: B return with SLVERR, then fill the master B buffer.
      @(negedge clk);
      s_b_valid[1] = 1'b1; s_b_resp[3:2] = 2'b10; s_b_id[1] = 1'b0;
      B_grant_f[1] = 1'b1; B_sel_f[1] = 1'b0; m_b_ready = '0;
      #1 chk("t3 s_b_ready", s_b_ready, 2'b10);
      @(negedge clk);
      s_b_valid = '0;
      #1 chk("t3 m_b_valid", m_b_valid, 2'b01);
      chk("t3 m_b_resp", m_b_resp[1:0], 2'b10);
      chk("t3 m_b_id", m_b_id[0], 1'b0);
      chk("t3 B_valid_f pulse", B_valid_f, 2'b10);
      @(negedge clk);
      #1 chk("t3 B_valid_f end", B_valid_f, 2'b00);
      s_b_valid[1] = 1'b1; s_b_resp[3:2] = 2'b00; s_b_id[1] = 1'b1;
      @(negedge clk);
      #1 chk("t3 s_b_ready full", s_b_ready[1], 1'b0);
      chk("t3 B_ready_f full", B_ready_f, 2'b10);
      s_b_valid = '0; m_b_ready[0] = 1'b1;
      @(negedge clk);
      #1 chk("t3 second resp", {m_b_valid[0], m_b_resp[1:0], m_b_id[0]}, {1'b1, 2'b00, 1'b1});
      @(negedge clk);
      #1 chk("t3 b drained", m_b_valid, 2'b00);
      B_grant_f = '0; m_b_ready = '0;

      // Test 4: W grant withdrawn with one beat buffered.
      @(negedge clk);
      s_w_ready[1] = 1'b0; W_grant_f[1] = 1'b1; W_sel_f[1] = 1'b1;
      drive_w(1, 32'hB0, 1'b1);
      #1 chk("t4 rdy B0", m_w_ready[1], 1'b1);
      @(negedge clk);
      W_grant_f[1] = 1'b0;
      drive_w(1, 32'hB1, 1'b1);
      #1 chk("t4 rdy ungranted", m_w_ready[1], 1'b0);
      s_w_ready[1] = 1'b1;
      chk("t4 B0 drains", {s_w_valid[1], s_w_data[63:32]}, {1'b1, 32'hB0});
      @(negedge clk);
      #1 chk("t4 B1 held", {s_w_valid[1], m_w_ready[1]}, 2'b00);
      @(negedge clk);
      #1 chk("t4 B1 still held", s_w_valid[1], 1'b0);
      W_grant_f[1] = 1'b1;
      #1 chk("t4 regrant rdy", m_w_ready[1], 1'b1);
      @(negedge clk);
      m_w_valid = '0; W_grant_f = '0;
      #1 chk("t4 B1 arrives", {s_w_valid[1], s_w_data[63:32]}, {1'b1, 32'hB1});
      @(negedge clk);

      // Test 5: illegal dual AW grant to slave 0.
      s_aw_ready[0] = 1'b0;
      m_aw_valid = 2'b11; AW_grant_f = 2'b11; AW_sel_f = 2'b00;
      m_aw_addr = {32'h0B0B_0000, 32'h0A0A_0000}; m_aw_id = 2'b00;
      #1 chk("t5 ready", m_aw_ready, 2'b01);
      @(negedge clk);
      m_aw_valid = '0; AW_grant_f = '0;
      #1 chk("t5 m0 beat", {s_aw_valid, s_aw_addr[31:0]}, {2'b01, 32'h0A0A_0000});
      s_aw_ready[0] = 1'b1;
      @(negedge clk);
      #1 chk("t5 no m1 beat", s_aw_valid, 2'b00);

      // Test 6: async clr with two W beats buffered.
      @(negedge clk);
      s_w_ready[0] = 1'b0; W_grant_f[0] = 1'b1; W_sel_f[0] = 1'b0;
      drive_w(0, 32'hC0, 1'b0);
      @(negedge clk);
      drive_w(0, 32'hC1, 1'b1);
      @(negedge clk);
      m_w_valid = '0;
      #1 chk("t6 full pre", {s_w_valid[0], m_w_ready[0]}, 2'b10);
      #2 clr = 1'b0;
      #1 chk("t6 async valid", {s_w_valid, s_aw_valid, m_b_valid}, 6'b0);
      chk("t6 async ready", m_w_ready, 2'b00);
      W_grant_f = '0;
      @(negedge clk);
      clr = 1'b1;
      s_w_ready[0] = 1'b1;
      @(negedge clk);
      #1 chk("t6 post clr empty", s_w_valid, 2'b00);
      @(negedge clk);
      #1 chk("t6 no stale beat", s_w_valid, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
